sram_mmio_responder: RTL and testbench



---
 rtl/sram_mmio_responder.sv | 120 ++++++++++++
 tb/tb_sram_mmio_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sram_mmio_responder.sv
// Data-SRAM responder: word RAM plus an MMIO window (LED, switch, timer, number display).
// Define RESP_WRITE_FIRST_EN to make a read and a write to the same word in one cycle return the merged new data.
module sram_mmio_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000,
    parameter logic [31:0] MMIO_MASK = 32'hffff_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    input  logic [7:0]  switch
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       r_mem [DEPTH];
    logic [15:0]       r_led;
    logic [31:0]       r_timer;
    logic [31:0]       r_num;
    logic [31:0]       r_rdata_p1;

    logic              w_mmio_hit;
    logic [15:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr;
    logic              w_ram_wr;
    logic              w_wr_led;
    logic              w_wr_timer;
    logic              w_wr_num;
    logic [31:0]       w_ram_old;
    logic [31:0]       w_rd_data;

    // Byte-lane merge: lanes with their enable set take new data, the rest keep old.
    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  we);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    assign w_mmio_hit = ((sram_addr & MMIO_MASK) == MMIO_BASE);
    assign w_off      = sram_addr[15:0];
    assign w_idx      = sram_addr[ADDR_W+1:2];
    assign w_ram_old  = r_mem[w_idx];

    assign w_wr       = resetn && sram_en && (sram_we != 4'b0000);
    assign w_ram_wr   = w_wr && !w_mmio_hit;
    assign w_wr_led   = w_wr && w_mmio_hit && (w_off == 16'h0000);
    assign w_wr_timer = w_wr && w_mmio_hit && (w_off == 16'h0008);
    assign w_wr_num   = w_wr && w_mmio_hit && (w_off == 16'h000C);

    always_comb begin
        w_rd_data = 32'h0;
        if (w_mmio_hit) begin
            case (w_off)
`ifdef RESP_WRITE_FIRST_EN
                16'h0000: w_rd_data = {16'h0, f_merge({16'h0, r_led}, sram_wdata, sram_we)};
                16'h0004: w_rd_data = {24'h0, switch};
                16'h0008: w_rd_data = f_merge(r_timer, sram_wdata, sram_we);
                16'h000C: w_rd_data = f_merge(r_num, sram_wdata, sram_we);
`else
                16'h0000: w_rd_data = {16'h0, r_led};
                16'h0004: w_rd_data = {24'h0, switch};
                16'h0008: w_rd_data = r_timer;
                16'h000C: w_rd_data = r_num;
`endif
                default:  w_rd_data = 32'h0;
            endcase
        end else begin
`ifdef RESP_WRITE_FIRST_EN
            w_rd_data = f_merge(w_ram_old, sram_wdata, sram_we);
`else
            w_rd_data = w_ram_old;
`endif
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_led   <= 16'h0;
            r_num   <= 32'h0;
            r_timer <= 32'h0;
        end else begin
            if (w_wr_led) r_led <= f_merge({16'h0, r_led}, sram_wdata, sram_we) & 32'h0000_FFFF;
            if (w_wr_num) r_num <= f_merge(r_num, sram_wdata, sram_we);
            // A write to TIMER replaces that cycle's increment.
            if (w_wr_timer) r_timer <= f_merge(r_timer, sram_wdata, sram_we);
            else            r_timer <= r_timer + 32'd1;
        end
    end

    // Stage p1: registered read data, one cycle after the request.
    always_ff @(posedge clk) begin
        if (!resetn)      r_rdata_p1 <= 32'h0;
        else if (sram_en) r_rdata_p1 <= w_rd_data;
    end

    assign sram_rdata = r_rdata_p1;
    assign led        = r_led;
    assign num_data   = r_num;

endmodule

// File: tb/tb_sram_mmio_responder.sv
// Directed self-checking bench for sram_mmio_responder; expectations follow RESP_WRITE_FIRST_EN when defined.
module tb_sram_mmio_responder;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [31:0] num_data;
    logic [7:0]  switch;

    int n_cmp;
    int n_fail;

    sram_mmio_responder dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led),
        .num_data   (num_data),
        .switch     (switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, then move to 1 time unit after the capturing edge.
    task automatic cyc(input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
        sram_en    = en;
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] rdw_exp;
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        switch = 8'h00;
        sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
        #1;
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset_rdata", sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_num", num_data, 32'h0);
        resetn = 1'b1;

        // RAM full-word write and read-back
        cyc(1'b1, 4'hF, 32'h1c00_0010, 32'h1234_5678);
        cyc(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        chk("ram_word", sram_rdata, 32'h1234_5678);

        // Partial byte enables
        cyc(1'b1, 4'b0101, 32'h1c00_0010, 32'hAABB_CCDD);
        cyc(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        chk("ram_bytes", sram_rdata, 32'h12BB_56DD);

        // Read-during-write on the same word
        cyc(1'b1, 4'hF, 32'h1c00_0020, 32'h1111_1111);
        cyc(1'b1, 4'hF, 32'h1c00_0020, 32'h2222_2222);
`ifdef RESP_WRITE_FIRST_EN
        rdw_exp = 32'h2222_2222;
`else
        rdw_exp = 32'h1111_1111;
`endif
        chk("ram_rdw", sram_rdata, rdw_exp);
        cyc(1'b1, 4'h0, 32'h1c00_0020, 32'h0);
        chk("ram_after_rdw", sram_rdata, 32'h2222_2222);

        // Aliasing through ignored upper index bits, then hold with en=0
        cyc(1'b1, 4'hF, 32'h1c00_0000, 32'hCAFE_F00D);
        cyc(1'b1, 4'h0, 32'h1c00_4000, 32'h0);
        chk("ram_alias", sram_rdata, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
            chk("rdata_hold", sram_rdata, 32'hCAFE_F00D);
        end

        // MMIO registers
        cyc(1'b1, 4'hF, 32'hbfaf_0000, 32'h0000_A5A5);
        chk("led_write", {16'h0, led}, 32'h0000_A5A5);
        cyc(1'b1, 4'hF, 32'hbfaf_000C, 32'hDEAD_BEEF);
        chk("num_write", num_data, 32'hDEAD_BEEF);
        switch = 8'h3C;
        cyc(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
        chk("switch_read", sram_rdata, 32'h0000_003C);
        cyc(1'b1, 4'h0, 32'hbfaf_0020, 32'h0);
        chk("unmapped_read", sram_rdata, 32'h0);
        cyc(1'b1, 4'hF, 32'hbfaf_0000, 32'h1234_5A5A);
        chk("led_upper_dropped", {16'h0, led}, 32'h0000_5A5A);
        cyc(1'b1, 4'h0, 32'hbfaf_0000, 32'h0);
        chk("led_read", sram_rdata, 32'h0000_5A5A);
        cyc(1'b1, 4'b0010, 32'hbfaf_000C, 32'h0000_7700);
        chk("num_byte", num_data, 32'hDEAD_77EF);

        // Timer wrap: value held during each request cycle is returned
        cyc(1'b1, 4'hF, 32'hbfaf_0008, 32'hFFFF_FFFE);
        cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
        chk("timer_t1", sram_rdata, 32'hFFFF_FFFE);
        cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
        chk("timer_t2", sram_rdata, 32'hFFFF_FFFF);
        cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
        chk("timer_wrap", sram_rdata, 32'h0);

        // Read immediately followed by reset; writes during reset are dropped
        cyc(1'b1, 4'h0, 32'h1c00_0000, 32'h0);
        chk("pre_reset_read", sram_rdata, 32'hCAFE_F00D);
        resetn = 1'b0;
        cyc(1'b1, 4'hF, 32'h1c00_0000, 32'h5555_AAAA);
        chk("reset_drop_rdata", sram_rdata, 32'h0);
        cyc(1'b1, 4'hF, 32'hbfaf_0000, 32'h0000_FFFF);
        chk("reset_led_clr", {16'h0, led}, 32'h0);
        chk("reset_num_clr", num_data, 32'h0);
        resetn = 1'b1;
        cyc(1'b1, 4'h0, 32'hbfaf_0008, 32'h0);
        chk("timer_after_reset", sram_rdata, 32'h0);
        cyc(1'b1, 4'h0, 32'h1c00_0000, 32'h0);
        chk("ram_write_in_reset", sram_rdata, 32'hCAFE_F00D);
        cyc(1'b1, 4'h0, 32'hbfaf_0000, 32'h0);
        chk("led_write_in_reset", sram_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
